uart_word_bridge: RTL and testbench
===================================

Name: uart_word_bridge

Overview:
- Sits between the byte-level uart_rx/uart_tx pair and the processor.
- RX side packs incoming UART bytes into WORD_BYTES-wide words and buffers them in a first-word-fall-through FIFO with a valid/ready interface.
- TX side accepts processor words on valid/ready and serialises them byte by byte into uart_tx, paced by its done pulse.
- Adds inter-byte timeout resync, overflow detection and configurable byte order, which a bare byte-per-byte link lacks.

Parameters:
- WORD_BYTES, 4: bytes per word, 1..8.
- FIFO_DEPTH, 8: RX word FIFO entries; power of two, at least 2.
- TIMEOUT_CLKS, 1200: idle clocks after which a partial RX word is discarded; 0 disables the timeout.
- MSB_FIRST, 0: 0 means the first byte on the wire is word[7:0]; 1 means the first byte is the most significant byte.

Ports:
- i_Clock  in  1  system clock
- i_Reset  in  1  asynchronous, active-high reset
- i_Rx_DV  in  1  one-cycle byte-valid pulse from uart_rx
- i_Rx_Byte  in  8  received byte
- o_Word_Valid  out  1  RX FIFO not empty
- o_Word  out  8*WORD_BYTES  FIFO head word
- i_Word_Ready  in  1  processor pops the head word when valid and ready
- i_Out_Valid  in  1  processor presents a TX word
- i_Out_Word  in  8*WORD_BYTES  TX word
- o_Out_Ready  out  1  TX holding register free
- o_Tx_DV  out  1  one-cycle start pulse to uart_tx
- o_Tx_Byte  out  8  byte to uart_tx
- i_Tx_Active  in  1  uart_tx busy
- i_Tx_Done  in  1  one-cycle done pulse from uart_tx
- o_Rx_Overflow  out  1  sticky: a word was dropped because the FIFO was full
- o_Rx_Timeout  out  1  one-cycle pulse when a partial word is discarded
- o_Rx_Chk_Err  out  1  one-cycle pulse on checksum mismatch; tied 0 without the macro

Behaviour:
- Reset (asynchronous, active-high, i_Reset) forces all outputs low except o_Out_Ready, which is 1 (TX holding register free):
  - o_Word_Valid=0, o_Tx_DV=0, flags=0
  - byte count=0, FIFO empty, TX FSM in IDLE
- Reset mid-word discards the partial word.
- A uart_tx byte already in flight completes on its own; an i_Tx_Done arriving in IDLE is ignored.
- RX assembly:
  - Each i_Rx_DV writes i_Rx_Byte into the lane given by the byte count and MSB_FIRST, then increments the count.
  - On the WORD_BYTES-th byte the assembled word is pushed into the FIFO on the next edge, and the count wraps to 0.
  - o_Word_Valid rises 2 cycles after the i_Rx_DV of the last byte.
- Timeout:
  - The idle counter clears on every i_Rx_DV.
  - If count>0 and the idle counter reaches TIMEOUT_CLKS, the count resets to 0 and o_Rx_Timeout pulses for 1 cycle.
  - If i_Rx_DV coincides with expiry, the byte wins: it is accepted and no timeout is raised.
- RX FIFO:
  - First-word fall-through; pop occurs when o_Word_Valid and i_Word_Ready.
  - A push while full is accepted only if a pop happens in the same cycle; otherwise the word is dropped and o_Rx_Overflow is set until reset.
  - Simultaneous push and pop when empty: the word is written, and o_Word_Valid rises next cycle.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally; an occupancy counter distinguishes full from empty.
- TX FSM states: IDLE, SEND, WAIT.
  - IDLE: o_Out_Ready=1. On i_Out_Valid the FSM captures i_Out_Word, clears the byte index and goes to SEND.
  - SEND: when i_Tx_Active=0, pulse o_Tx_DV for 1 cycle with the selected byte and go to WAIT; otherwise stay in SEND.
  - WAIT: on i_Tx_Done, increment the byte index. If the last byte has been sent, go to IDLE; otherwise go to SEND.
  - Latency: a word accepted at edge N gives o_Tx_DV at cycle N+1 if uart_tx is idle.
  - o_Out_Ready is 0 in SEND and WAIT. There is no TX FIFO.

Optional Feature:
- Macro: UART_BRIDGE_CHECKSUM_EN.
- Defined, TX side: after the last data byte, one extra byte equal to the XOR of all word bytes is sent through the same SEND/WAIT sequence.
- Defined, RX side:
  - A frame is WORD_BYTES+1 bytes. The final byte is compared with the running XOR of the data bytes.
  - Match: the word is pushed.
  - Mismatch: the word is dropped, o_Rx_Chk_Err pulses for 1 cycle, and the count resets.
  - Timeout applies to partial frames.
- Undefined: no checksum byte on either side, and o_Rx_Chk_Err is constant 0.

Test Plan:
- Byte assembly: defaults, bytes 0x11,0x22,0x33,0x44 with i_Word_Ready=1 -> one o_Word_Valid cycle with o_Word=0x44332211; with MSB_FIRST=1 -> 0x11223344.
- Timeout: TIMEOUT_CLKS=100; send 0xAA,0xBB, idle 100 clocks -> o_Rx_Timeout pulse, no word. Then send 0x01,0x02,0x03,0x04 -> 0x04030201.
- Overflow and simultaneous push/pop:
  - i_Word_Ready=0, 9 words -> 8 words drain in order and o_Rx_Overflow=1.
  - Repeat with pop coinciding with the 9th push -> no overflow.
- TX serialisation: i_Out_Word=0xA1B2C3D4 with a uart_tx model -> o_Tx_Byte D4, C3, B2, A1. Each o_Tx_DV comes only after the previous i_Tx_Done, and o_Out_Ready=0 until the cycle after the final i_Tx_Done.
- Reset mid-operation: assert i_Reset after 2 RX bytes and during TX byte 2 -> outputs at reset values immediately. Next 4 RX bytes form a clean word; a stray i_Tx_Done causes no o_Tx_DV.
- Checksum (macro defined):
  - Bytes 01,02,03,04,04 -> word 0x04030201 pushed.
  - Final byte 0x05 -> o_Rx_Chk_Err pulse, no word.
  - TX of 0x04030201 sends a 5th byte, 0x04.

Source files
------------

// File: rtl/uart_word_bridge.sv
// uart_word_bridge: packs UART bytes into words for the processor (RX path with
// a first-word-fall-through FIFO) and serialises processor words into uart_tx
// (TX path, one holding register). Inter-byte timeout discards partial words.
// Optional feature: define UART_BRIDGE_CHECKSUM_EN to append/verify an XOR
// checksum byte after every word on both directions.
module uart_word_bridge #(
  parameter int WORD_BYTES   = 4,
  parameter int FIFO_DEPTH   = 8,
  parameter int TIMEOUT_CLKS = 1200,
  parameter int MSB_FIRST    = 0
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset,
  input  logic                      i_Rx_DV,
  input  logic [7:0]                i_Rx_Byte,
  output logic                      o_Word_Valid,
  output logic [8*WORD_BYTES-1:0]   o_Word,
  input  logic                      i_Word_Ready,
  input  logic                      i_Out_Valid,
  input  logic [8*WORD_BYTES-1:0]   i_Out_Word,
  output logic                      o_Out_Ready,
  output logic                      o_Tx_DV,
  output logic [7:0]                o_Tx_Byte,
  input  logic                      i_Tx_Active,
  input  logic                      i_Tx_Done,
  output logic                      o_Rx_Overflow,
  output logic                      o_Rx_Timeout,
  output logic                      o_Rx_Chk_Err
);

  localparam int WORD_W = 8 * WORD_BYTES;
`ifdef UART_BRIDGE_CHECKSUM_EN
  localparam int FRAME_BYTES = WORD_BYTES + 1;
`else
  localparam int FRAME_BYTES = WORD_BYTES;
`endif
  localparam int CNT_W    = $clog2(FRAME_BYTES + 1);
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int OCC_W    = PTR_W + 1;
  localparam int IDLE_W   = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam int IDLE_LIM = (TIMEOUT_CLKS > 0) ? TIMEOUT_CLKS - 1 : 0;

  // Wire order index -> byte lane inside the word
  function automatic int lane_of(input int idx);
    return (MSB_FIRST != 0) ? (WORD_BYTES - 1 - idx) : idx;
  endfunction

  function automatic logic [7:0] get_byte(input logic [WORD_W-1:0] w, input int idx);
    logic [WORD_W-1:0] s;
    if (idx >= WORD_BYTES) return 8'h00;
    s = w >> (8 * lane_of(idx));
    return s[7:0];
  endfunction

  function automatic logic [WORD_W-1:0] put_byte(input logic [WORD_W-1:0] w, input int idx,
                                                 input logic [7:0] b);
    logic [WORD_W-1:0] r;
    r = w;
    if (idx < WORD_BYTES) r[8*lane_of(idx) +: 8] = b;
    return r;
  endfunction

`ifdef UART_BRIDGE_CHECKSUM_EN
  function automatic logic [7:0] xor_bytes(input logic [WORD_W-1:0] w);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < WORD_BYTES; i++) x = x ^ w[8*i +: 8];
    return x;
  endfunction
`endif

  // ---------------- RX assembly ----------------
  logic [CNT_W-1:0]  rx_cnt;
  logic [IDLE_W-1:0] idle_cnt;
  logic [WORD_W-1:0] asm_word, word_in, push_word;
  logic              push_pend, timeout_q, chk_err_q;
  logic              last_rx, expire;
`ifdef UART_BRIDGE_CHECKSUM_EN
  logic [7:0]        rx_xor;
`endif

  assign last_rx = (rx_cnt == CNT_W'(FRAME_BYTES - 1));
  assign expire  = (TIMEOUT_CLKS != 0) && (rx_cnt != '0) && !i_Rx_DV &&
                   (idle_cnt == IDLE_W'(IDLE_LIM));
  assign word_in = put_byte(asm_word, int'(rx_cnt), i_Rx_Byte);

  // Byte counter, idle timer and the one-cycle push/flag strobes
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      rx_cnt    <= '0;
      idle_cnt  <= '0;
      push_pend <= 1'b0;
      timeout_q <= 1'b0;
      chk_err_q <= 1'b0;
    end else begin
      push_pend <= 1'b0;
      timeout_q <= 1'b0;
      chk_err_q <= 1'b0;
      if (i_Rx_DV) begin
        idle_cnt <= '0;
        if (last_rx) begin
          rx_cnt <= '0;
`ifdef UART_BRIDGE_CHECKSUM_EN
          if (i_Rx_Byte == rx_xor) push_pend <= 1'b1;
          else                     chk_err_q <= 1'b1;
`else
          push_pend <= 1'b1;
`endif
        end else begin
          rx_cnt <= rx_cnt + 1'b1;
        end
      end else if (expire) begin
        rx_cnt    <= '0;
        idle_cnt  <= '0;
        timeout_q <= 1'b1;
      end else if (rx_cnt == '0) begin
        idle_cnt <= '0;
      end else if (idle_cnt != IDLE_W'(IDLE_LIM)) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  // Word being assembled and the completed word waiting for the FIFO write
  always_ff @(posedge i_Clock) begin
    if (i_Rx_DV) begin
      asm_word <= word_in;
      if (last_rx) push_word <= word_in;
`ifdef UART_BRIDGE_CHECKSUM_EN
      rx_xor <= (rx_cnt == '0) ? i_Rx_Byte : (rx_xor ^ i_Rx_Byte);
`endif
    end
  end

  // ---------------- RX FIFO ----------------
  logic [WORD_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [OCC_W-1:0]  occ;
  logic              overflow_q, pop, full, accept;

  assign pop    = (occ != '0) && i_Word_Ready;
  assign full   = (occ == OCC_W'(FIFO_DEPTH));
  assign accept = push_pend && (!full || pop);

  // Pointers, occupancy and sticky overflow
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      if (accept && !pop)      occ <= occ + 1'b1;
      else if (!accept && pop) occ <= occ - 1'b1;
      if (push_pend && !accept) overflow_q <= 1'b1;
    end
  end

  // Storage array
  always_ff @(posedge i_Clock) begin
    if (accept) mem[wr_ptr] <= push_word;
  end

  assign o_Word_Valid  = (occ != '0);
  assign o_Word        = o_Word_Valid ? mem[rd_ptr] : '0;
  assign o_Rx_Overflow = overflow_q;
  assign o_Rx_Timeout  = timeout_q;
`ifdef UART_BRIDGE_CHECKSUM_EN
  assign o_Rx_Chk_Err  = chk_err_q;
`else
  assign o_Rx_Chk_Err  = 1'b0;
  logic unused_chk;
  assign unused_chk = chk_err_q;
`endif

  // ---------------- TX serialiser ----------------
  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT} tx_state_t;
  tx_state_t         state, state_nxt;
  logic [CNT_W-1:0]  tx_idx, tx_idx_nxt;
  logic [WORD_W-1:0] tx_word;
  logic [7:0]        tx_sel;
  logic              load;

  // State and byte index registers
  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state  <= S_IDLE;
      tx_idx <= '0;
    end else begin
      state  <= state_nxt;
      tx_idx <= tx_idx_nxt;
    end
  end

  // Next state, handshake and start pulse
  always_comb begin
    state_nxt   = state;
    tx_idx_nxt  = tx_idx;
    o_Out_Ready = 1'b0;
    o_Tx_DV     = 1'b0;
    load        = 1'b0;
    case (state)
      S_IDLE: begin
        o_Out_Ready = 1'b1;
        if (i_Out_Valid) begin
          load       = 1'b1;
          tx_idx_nxt = '0;
          state_nxt  = S_SEND;
        end
      end
      S_SEND: begin
        if (!i_Tx_Active) begin
          o_Tx_DV   = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (i_Tx_Done) begin
          tx_idx_nxt = tx_idx + 1'b1;
          state_nxt  = (tx_idx == CNT_W'(FRAME_BYTES - 1)) ? S_IDLE : S_SEND;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Holding register for the word being sent
  always_ff @(posedge i_Clock) begin
    if (load) tx_word <= i_Out_Word;
  end

`ifdef UART_BRIDGE_CHECKSUM_EN
  assign tx_sel = (tx_idx == CNT_W'(WORD_BYTES)) ? xor_bytes(tx_word)
                                                  : get_byte(tx_word, int'(tx_idx));
`else
  assign tx_sel = get_byte(tx_word, int'(tx_idx));
`endif
  assign o_Tx_Byte = (state == S_SEND) ? tx_sel : 8'h00;

endmodule

// File: tb/tb_uart_word_bridge.sv
// Testbench for uart_word_bridge: two instances (LSB-first and MSB-first) share
// the RX stimulus; a scoreboard queue per output stream is checked by monitors.
module tb_uart_word_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        word_ready = 1'b1;
  logic        out_valid = 1'b0;
  logic [31:0] out_word = 32'h0;
  logic        tx_active = 1'b0;
  logic        model_done = 1'b0;
  logic        stray_done = 1'b0;
  logic        tx_done_in;

  logic        word_valid, out_ready, tx_dv, ovf, rx_to, chk_err;
  logic [31:0] word;
  logic [7:0]  tx_byte;
  logic        m_word_valid, m_out_ready, m_tx_dv, m_ovf, m_to, m_chk;
  logic [31:0] m_word;
  logic [7:0]  m_tx_byte;

  assign tx_done_in = model_done | stray_done;

  always #5 clk = ~clk;

  uart_word_bridge #(.WORD_BYTES(4), .FIFO_DEPTH(8), .TIMEOUT_CLKS(100), .MSB_FIRST(0)) dut (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Word_Valid(word_valid), .o_Word(word), .i_Word_Ready(word_ready),
    .i_Out_Valid(out_valid), .i_Out_Word(out_word), .o_Out_Ready(out_ready),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte), .i_Tx_Active(tx_active), .i_Tx_Done(tx_done_in),
    .o_Rx_Overflow(ovf), .o_Rx_Timeout(rx_to), .o_Rx_Chk_Err(chk_err));

  uart_word_bridge #(.WORD_BYTES(4), .FIFO_DEPTH(8), .TIMEOUT_CLKS(100), .MSB_FIRST(1)) dut_msb (
    .i_Clock(clk), .i_Reset(rst), .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Word_Valid(m_word_valid), .o_Word(m_word), .i_Word_Ready(word_ready),
    .i_Out_Valid(1'b0), .i_Out_Word(32'h0), .o_Out_Ready(m_out_ready),
    .o_Tx_DV(m_tx_dv), .o_Tx_Byte(m_tx_byte), .i_Tx_Active(1'b0), .i_Tx_Done(1'b0),
    .o_Rx_Overflow(m_ovf), .o_Rx_Timeout(m_to), .o_Rx_Chk_Err(m_chk));

  int vectors = 0;
  int miscompares = 0;
  int to_cnt = 0, chk_cnt = 0, dv_cnt = 0;
  int cyc = 0, last_done_cyc = 0;
  logic [31:0] rx_exp[$];
  logic [31:0] rx_exp_m[$];
  logic [7:0]  tx_exp[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Scoreboard monitors: compare each popped word / started byte with the queue head
  always @(negedge clk) begin : mon
    logic [31:0] e;
    logic [7:0]  eb;
    if (word_valid && word_ready) begin
      if (rx_exp.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rx_unexpected: got word %0h, required none", word);
      end else begin
        e = rx_exp.pop_front();
        check("rx_word", word, e);
      end
    end
    if (m_word_valid && word_ready) begin
      if (rx_exp_m.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL rx_msb_unexpected: got word %0h, required none", m_word);
      end else begin
        e = rx_exp_m.pop_front();
        check("rx_msb_word", m_word, e);
      end
    end
    if (tx_dv) begin
      dv_cnt++;
      check("tx_dv_while_busy", tx_active, 0);
      if (tx_exp.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL tx_unexpected: got byte %0h, required none", tx_byte);
      end else begin
        eb = tx_exp.pop_front();
        check("tx_byte", tx_byte, eb);
      end
    end
    if (rx_to)   to_cnt++;
    if (chk_err) chk_cnt++;
  end

  // uart_tx model: busy for a few clocks after each start pulse, then done
  initial forever begin
    @(negedge clk);
    if (tx_dv) begin
      @(posedge clk); #1 tx_active = 1'b1;
      repeat (3) @(posedge clk);
      #1 tx_active = 1'b0; model_done = 1'b1; last_done_cyc = cyc;
      @(posedge clk); #1 model_done = 1'b0;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_dv = 1'b1; rx_byte = b; tick(1);
    rx_dv = 1'b0; tick(1);
  endtask

  function automatic logic [7:0] xor4(input logic [31:0] w);
    return w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
  endfunction

  // Sends a word LSB first on the wire; optionally raises ready in the cycle the word is pushed
  task automatic send_frame(input logic [31:0] w, input bit pop_on_last);
    logic [7:0] bytes[$];
    for (int i = 0; i < 4; i++) bytes.push_back(w[8*i +: 8]);
`ifdef UART_BRIDGE_CHECKSUM_EN
    bytes.push_back(xor4(w));
`endif
    for (int i = 0; i < bytes.size() - 1; i++) send_byte(bytes[i]);
    rx_dv = 1'b1; rx_byte = bytes[bytes.size() - 1]; tick(1);
    rx_dv = 1'b0;
    if (pop_on_last) word_ready = 1'b1;
    tick(1);
  endtask

  task automatic expect_word(input logic [31:0] lsb_word, input logic [31:0] msb_word);
    rx_exp.push_back(lsb_word);
    rx_exp_m.push_back(msb_word);
  endtask

  task automatic wait_rx_drain(input int bound);
    for (int n = 0; n < bound && (rx_exp.size() + rx_exp_m.size()) != 0; n++) tick(1);
    check("rx_drain", rx_exp.size() + rx_exp_m.size(), 0);
  endtask

  task automatic expect_tx(input logic [31:0] w);
    for (int i = 0; i < 4; i++) tx_exp.push_back(w[8*i +: 8]);
`ifdef UART_BRIDGE_CHECKSUM_EN
    tx_exp.push_back(xor4(w));
`endif
  endtask

  initial begin
    int t0, d0, rdy_cyc;
    logic [31:0] w;
    tick(3);
    // Reset values while reset is held
    check("rst_word_valid", word_valid, 0);
    check("rst_out_ready", out_ready, 1);
    check("rst_tx_dv", tx_dv, 0);
    check("rst_overflow", ovf, 0);
    check("rst_timeout", rx_to, 0);
    check("rst_chk_err", chk_err, 0);
    rst = 1'b0;
    tick(2);

    // Byte assembly, both byte orders
    expect_word(32'h44332211, 32'h11223344);
    send_frame(32'h44332211, 1'b0);
    wait_rx_drain(20);

    // Timeout discards a partial word, next word is clean
    t0 = to_cnt;
    send_byte(8'hAA);
    send_byte(8'hBB);
    tick(105);
    check("timeout_pulses", to_cnt - t0, 1);
    check("timeout_no_word", word_valid, 0);
    expect_word(32'h04030201, 32'h01020304);
    send_frame(32'h04030201, 1'b0);
    wait_rx_drain(20);

    // Overflow: nine words with nothing popped, the ninth is dropped
    word_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      w = 32'hC0DE0000 | 32'(k);
      if (k < 8) expect_word(w, {w[7:0], w[15:8], w[23:16], w[31:24]});
      send_frame(w, 1'b0);
    end
    tick(3);
    check("overflow_set", ovf, 1);
    check("full_valid", word_valid, 1);
    word_ready = 1'b1;
    wait_rx_drain(40);
    check("overflow_sticky", ovf, 1);
    rst = 1'b1; tick(1); rst = 1'b0; tick(1);
    check("overflow_cleared", ovf, 0);

    // Pop coinciding with the push into a full FIFO: nothing lost
    word_ready = 1'b0;
    for (int k = 0; k < 9; k++) begin
      w = 32'h5A5A0000 | 32'(k);
      expect_word(w, {w[7:0], w[15:8], w[23:16], w[31:24]});
      send_frame(w, k == 8);
    end
    wait_rx_drain(40);
    check("no_overflow", ovf, 0);

    // TX serialisation
    expect_tx(32'hA1B2C3D4);
    out_word = 32'hA1B2C3D4; out_valid = 1'b1;
    check("tx_ready_idle", out_ready, 1);
    tick(1);
    out_valid = 1'b0;
    check("tx_ready_busy", out_ready, 0);
    check("tx_first_dv", tx_dv, 1);
    rdy_cyc = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (out_ready) begin rdy_cyc = cyc; break; end
    end
    tick(1);
    check("tx_ready_after_done", rdy_cyc, last_done_cyc + 1);
    check("tx_bytes_sent", tx_exp.size(), 0);

    // Reset mid-operation: partial RX word and TX byte 2 in flight
    send_byte(8'h55);
    send_byte(8'h66);
    expect_tx(32'h0BADF00D);
    out_word = 32'h0BADF00D; out_valid = 1'b1; tick(1); out_valid = 1'b0;
    for (int n = 0; n < 100 && tx_exp.size() > 2; n++) tick(1);
    check("tx_two_sent", tx_exp.size(), 2);
    tick(1);
    #2 rst = 1'b1;
    #1;
    check("midrst_word_valid", word_valid, 0);
    check("midrst_out_ready", out_ready, 1);
    check("midrst_tx_dv", tx_dv, 0);
    check("midrst_tx_byte", tx_byte, 0);
    tx_exp.delete();
    tick(2);
    rst = 1'b0;
    tick(6);
    d0 = dv_cnt;
    stray_done = 1'b1; tick(1); stray_done = 1'b0;
    tick(5);
    check("stray_done_no_dv", dv_cnt - d0, 0);
    check("stray_done_ready", out_ready, 1);
    expect_word(32'hDEADBEEF, 32'hEFBEADDE);
    send_frame(32'hDEADBEEF, 1'b0);
    wait_rx_drain(20);

`ifdef UART_BRIDGE_CHECKSUM_EN
    // Checksum: good frame pushes, bad frame pulses the error, TX appends XOR
    expect_word(32'h04030201, 32'h01020304);
    send_frame(32'h04030201, 1'b0);
    wait_rx_drain(20);
    t0 = chk_cnt;
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04); send_byte(8'h05);
    tick(3);
    check("chk_err_pulses", chk_cnt - t0, 1);
    check("chk_err_no_word", word_valid, 0);
    tx_exp.push_back(8'h01); tx_exp.push_back(8'h02); tx_exp.push_back(8'h03);
    tx_exp.push_back(8'h04); tx_exp.push_back(8'h04);
    out_word = 32'h04030201; out_valid = 1'b1; tick(1); out_valid = 1'b0;
    for (int n = 0; n < 400 && !(tx_exp.size() == 0 && out_ready); n++) tick(1);
    check("chk_tx_bytes", tx_exp.size(), 0);
`endif

    tick(10);
    check("rx_queue_empty", rx_exp.size() + rx_exp_m.size(), 0);
    check("tx_queue_empty", tx_exp.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
